// File: rtl/gshare_btb_if.sv
// Pipeline-facing bus of the branch prediction unit: fetch lookup,
// EX-stage resolution and the mispredict flush/redirect it produces.
interface gshare_btb_if #(
  parameter int PC_W  = 32,
  parameter int GHR_W = 4
);
  logic             memory_stall;
  logic [PC_W-1:0]  fetch_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic             upd_is_branch;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [PC_W-1:0]  upd_pred_target;
  logic [GHR_W-1:0] upd_ghr;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;

  // Pipeline side: drives fetch and resolution, consumes prediction and flush
  modport master (
    output memory_stall, fetch_pc,
    output upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
    output upd_pred_taken, upd_pred_target, upd_ghr,
    input  pred_taken, pred_target, pred_ghr, flush, redirect_pc
  );

  // Predictor side
  modport slave (
    input  memory_stall, fetch_pc,
    input  upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
    input  upd_pred_taken, upd_pred_target, upd_ghr,
    output pred_taken, pred_target, pred_ghr, flush, redirect_pc
  );
endinterface

// File: rtl/gshare_btb.sv
// Tagged branch target buffer with per-entry saturating counters,
// optionally gshare-indexed by a global history register. Prediction and
// mispredict detection are combinational; table/GHR writes land on the
// next rising clock edge.
module gshare_btb #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 4,
  parameter int USE_GHR = 1
) (
  input logic         clk,
  input logic         rst_n,
  gshare_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(2 ** (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(2 ** (CNT_W - 1) - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];
  logic [GHR_W-1:0]   ghr_q, ghr_d;

  logic [IDX_W-1:0]   fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic               fetch_hit;
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               branch_mispredict;
  logic               alias_mispredict;

  function automatic logic [IDX_W-1:0] table_index(
    input logic [PC_W-1:0]  pc,
    input logic [GHR_W-1:0] g
  );
    logic [IDX_W-1:0] base;
    base = pc[IDX_W+1:2];
    if (USE_GHR != 0) begin
      return base ^ IDX_W'(g);
    end
    return base;
  endfunction

  // Fetch-side lookup; outputs forced to their idle values while in reset
  always_comb begin
    fetch_idx       = table_index(bus.fetch_pc, ghr_q);
    fetch_tag       = bus.fetch_pc[IDX_W+2 +: TAG_W];
    fetch_hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    bus.pred_taken  = rst_n && fetch_hit && cnt_q[fetch_idx][CNT_W-1];
    bus.pred_target = bus.pred_taken ? target_q[fetch_idx]
                                     : bus.fetch_pc + PC_W'(4);
    bus.pred_ghr    = rst_n ? ghr_q : '0;
  end

  // Mispredict detection from the EX-stage resolution, independent of stall
  always_comb begin
    branch_mispredict = bus.upd_is_branch &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));
    alias_mispredict  = !bus.upd_is_branch && bus.upd_pred_taken;
    bus.flush         = bus.upd_valid && rst_n && (branch_mispredict || alias_mispredict);
    bus.redirect_pc   = '0;
    if (bus.flush) begin
      bus.redirect_pc = (bus.upd_is_branch && bus.upd_taken) ? bus.upd_target
                                                             : bus.upd_pc + PC_W'(4);
    end
  end

  // Next table and history contents for a resolved instruction
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    ghr_d    = ghr_q;
    upd_idx  = table_index(bus.upd_pc, bus.upd_ghr);
    upd_tag  = bus.upd_pc[IDX_W+2 +: TAG_W];
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    if (bus.upd_valid && !bus.memory_stall) begin
      if (bus.upd_is_branch) begin
        ghr_d = (ghr_q << 1) | GHR_W'(bus.upd_taken);
        if (upd_hit) begin
          if (bus.upd_taken) begin
            target_d[upd_idx] = bus.upd_target;
            if (cnt_q[upd_idx] != CNT_MAX) begin
              cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
            end
          end else if (cnt_q[upd_idx] != '0) begin
            cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
          end
        end else if (bus.upd_taken) begin
          valid_d[upd_idx]  = 1'b1;
          tag_d[upd_idx]    = upd_tag;
          target_d[upd_idx] = bus.upd_target;
          cnt_d[upd_idx]    = CNT_WEAK_T;
        end
      end else if (bus.upd_pred_taken && upd_hit) begin
        valid_d[upd_idx] = 1'b0;
      end
    end
  end

  // Table and history registers; reset leaves every counter weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ghr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WEAK_NT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ghr_q    <= ghr_d;
    end
  end
endmodule

// File: tb/tb_gshare_btb.sv
// Bench for gshare_btb: directed walk through allocation, counter
// saturation, stall, alias invalidation and async reset, then randomized
// traffic, all checked every cycle against a behavioural table model.
module tb_gshare_btb;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int PC_W    = 32;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int GHR_W   = 4;
  localparam int USE_GHR = 1;
  localparam int CNT_TOP = (1 << CNT_W) - 1;
  localparam int CNT_HALF = 1 << (CNT_W - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic check_en = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Behavioural model of the predictor state
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_target[ENTRIES];
  int          m_cnt   [ENTRIES];
  int          m_ghr;

  gshare_btb_if #(.PC_W(PC_W), .GHR_W(GHR_W)) bus ();

  gshare_btb #(
    .ENTRIES(ENTRIES), .PC_W(PC_W), .TAG_W(TAG_W),
    .CNT_W(CNT_W), .GHR_W(GHR_W), .USE_GHR(USE_GHR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc, input int g);
    return ((int'(pc) >>> 2) ^ (USE_GHR != 0 ? g : 0)) & (ENTRIES - 1);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'(pc >> (IDX_W + 2)) & ((1 << TAG_W) - 1);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_cnt[i]    = CNT_HALF - 1;
    end
    m_ghr = 0;
  endtask

  task automatic modelUpdate();
    int  i;
    bit  hit;
    i   = idx_of(bus.upd_pc, int'(bus.upd_ghr));
    hit = m_valid[i] && (m_tag[i] == tag_of(bus.upd_pc));
    if (bus.upd_is_branch) begin
      if (hit) begin
        if (bus.upd_taken) begin
          m_cnt[i]    = (m_cnt[i] < CNT_TOP) ? m_cnt[i] + 1 : CNT_TOP;
          m_target[i] = bus.upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (bus.upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(bus.upd_pc);
        m_target[i] = bus.upd_target;
        m_cnt[i]    = CNT_HALF;
      end
      m_ghr = (m_ghr * 2 + int'(bus.upd_taken)) % (1 << GHR_W);
    end else if (bus.upd_pred_taken && hit) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // Model state follows the same clock and asynchronous reset as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelReset();
    end else if (bus.upd_valid && !bus.memory_stall) begin
      modelUpdate();
    end
  end

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs derived from the model and current inputs
  task automatic checkOutput();
    int          i;
    bit          e_taken;
    logic [31:0] e_target;
    bit          mis;
    bit          e_flush;
    logic [31:0] e_redirect;
    i        = idx_of(bus.fetch_pc, m_ghr);
    e_taken  = rst_n && m_valid[i] && (m_tag[i] == tag_of(bus.fetch_pc)) && (m_cnt[i] >= CNT_HALF);
    e_target = e_taken ? m_target[i] : bus.fetch_pc + 32'd4;
    mis = bus.upd_is_branch ? ((bus.upd_taken != bus.upd_pred_taken) ||
                               (bus.upd_taken && bus.upd_pred_target != bus.upd_target))
                            : bus.upd_pred_taken;
    e_flush    = rst_n && bus.upd_valid && mis;
    e_redirect = !e_flush ? 32'd0 :
                 (bus.upd_is_branch && bus.upd_taken) ? bus.upd_target : bus.upd_pc + 32'd4;
    compareValue("pred_taken", 32'(bus.pred_taken), 32'(e_taken));
    compareValue("pred_target", bus.pred_target, e_target);
    compareValue("pred_ghr", 32'(bus.pred_ghr), rst_n ? 32'(m_ghr) : 32'd0);
    compareValue("flush", 32'(bus.flush), 32'(e_flush));
    compareValue("redirect_pc", bus.redirect_pc, e_redirect);
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput();
    end
  end

  task automatic applyStimulus(
    input bit valid, input bit is_branch, input logic [31:0] pc, input bit taken,
    input logic [31:0] target, input bit ptaken, input logic [31:0] ptarget,
    input logic [3:0] ghr, input bit stall, input logic [31:0] fetch
  );
    bus.upd_valid       = valid;
    bus.upd_is_branch   = is_branch;
    bus.upd_pc          = pc;
    bus.upd_taken       = taken;
    bus.upd_target      = target;
    bus.upd_pred_taken  = ptaken;
    bus.upd_pred_target = ptarget;
    bus.upd_ghr         = ghr;
    bus.memory_stall    = stall;
    bus.fetch_pc        = fetch;
  endtask

  task automatic idleFetch(input logic [31:0] fetch);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, fetch);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic checkPred(input string name, input bit taken, input logic [31:0] target, input logic [3:0] ghr);
    compareValue({name, ".pred_taken"}, 32'(bus.pred_taken), 32'(taken));
    compareValue({name, ".pred_target"}, bus.pred_target, target);
    compareValue({name, ".pred_ghr"}, 32'(bus.pred_ghr), 32'(ghr));
  endtask

  task automatic checkFlush(input string name, input bit fl, input logic [31:0] redirect);
    compareValue({name, ".flush"}, 32'(bus.flush), 32'(fl));
    compareValue({name, ".redirect_pc"}, bus.redirect_pc, redirect);
  endtask

  // Directed sequence with hand-computed expectations, then random traffic
  initial begin
    logic [31:0] pool [8];
    logic [31:0] tgts [4];
    pool = '{32'h40, 32'h44, 32'h48, 32'h80, 32'h1040, 32'h1044, 32'h7C, 32'h2084};
    tgts = '{32'h100, 32'h200, 32'h300, 32'h1000};

    idleFetch(32'h40);
    #1 rst_n = 1'b0;
    modelReset();
    #12 rst_n = 1'b1;
    check_en = 1'b1;

    nextCycle(); idleFetch(32'h40); settle();
    checkPred("reset", 1'b0, 32'h44, 4'h0);

    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 32'h40);
    settle();
    checkFlush("alloc", 1'b1, 32'h100);
    checkPred("alloc_prewrite", 1'b0, 32'h44, 4'h0);

    nextCycle(); idleFetch(32'h40); settle();
    checkPred("ghr_miss", 1'b0, 32'h44, 4'h1);
    nextCycle(); idleFetch(32'h44); settle();
    checkPred("ghr_hit", 1'b1, 32'h100, 4'h1);

    for (int k = 0; k < 2; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 4'h0, 1'b0, 32'h44);
      settle();
      checkFlush("taken_ok", 1'b0, 32'h0);
    end

    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 4'h0, 1'b0, 32'h44);
    settle();
    checkFlush("nt1", 1'b1, 32'h44);
    nextCycle(); idleFetch(32'h78); settle();
    checkPred("cnt2", 1'b1, 32'h100, 4'hE);

    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 4'h0, 1'b0, 32'h78);
    settle();
    checkFlush("nt2", 1'b1, 32'h44);
    nextCycle(); idleFetch(32'h70); settle();
    checkPred("cnt1", 1'b0, 32'h74, 4'hC);

    for (int k = 0; k < 2; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 1'b1, 32'h70);
      settle();
      checkFlush("stall", 1'b1, 32'h100);
      checkPred("stall_hold", 1'b0, 32'h74, 4'hC);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 32'h70);
    nextCycle(); idleFetch(32'h64); settle();
    checkPred("unstall_once", 1'b1, 32'h100, 4'h9);

    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 4'h0, 1'b0, 32'h64);
    settle();
    checkFlush("alias", 1'b1, 32'h44);
    nextCycle(); idleFetch(32'h64); settle();
    checkPred("alias_inval", 1'b0, 32'h68, 4'h9);

    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 1'b0, 32'h64);
    settle();
    checkFlush("pre_reset", 1'b1, 32'h200);
    rst_n = 1'b0;
    #1;
    checkFlush("in_reset", 1'b0, 32'h0);
    checkPred("in_reset", 1'b0, 32'h68, 4'h0);
    nextCycle(); #2 rst_n = 1'b1;
    idleFetch(32'h40); settle();
    checkPred("after_reset", 1'b0, 32'h44, 4'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] upc;
      logic [31:0] utgt;
      logic [31:0] fpc;
      upc  = pool[$urandom_range(0, 7)];
      utgt = tgts[$urandom_range(0, 3)];
      fpc  = ($urandom_range(0, 3) == 0) ? 32'h40 + 32'(4 * $urandom_range(0, 15))
                                         : pool[$urandom_range(0, 7)];
      nextCycle();
      applyStimulus(
        $urandom_range(0, 9) < 7,
        $urandom_range(0, 9) < 8,
        upc,
        1'($urandom_range(0, 1)),
        utgt,
        1'($urandom_range(0, 1)),
        ($urandom_range(0, 1) == 1) ? utgt : tgts[$urandom_range(0, 3)],
        ($urandom_range(0, 1) == 1) ? 4'(m_ghr) : 4'($urandom_range(0, 15)),
        $urandom_range(0, 9) < 2,
        fpc
      );
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    nextCycle();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
